// File: rtl/exploit_uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a baud-timed framer, frames sent back-to-back.
// Latency: accepted byte popped next edge, tx falls after it; s_ready drops only while the FIFO is full.
module exploit_uart_tx #(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        tx,
  output logic        busy,
  output logic [15:0] tx_count
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic [15:0]   r_frames;
  logic          r_live;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        w_state_nxt;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_tx_nxt;
  logic          w_pop;
  logic          w_done;
  logic          w_push;
  logic          w_empty;
  logic          w_baud_zero;
  logic [7:0]    w_head;

  // r_live keeps s_ready low on the reset edge and until the first edge out of reset
  assign s_ready     = r_live && (r_count != FULL_CNT);
  assign w_push      = s_valid && s_ready;
  assign w_empty     = (r_count == '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_zero = (r_baud == '0);
  assign tx          = r_tx;
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign tx_count    = r_frames;

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_baud_nxt  = BAUD_LAST;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_zero) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = 3'd0;
          w_baud_nxt  = BAUD_LAST;
        end else begin
          w_baud_nxt = r_baud - BW'(1);
        end
      end
      S_DATA: begin
        if (w_baud_zero) begin
          w_baud_nxt = BAUD_LAST;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_idx_nxt   = 3'd0;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_nxt = r_baud - BW'(1);
        end
      end
      S_STOP: begin
        // r_idx counts stop bits here; the last one chains straight into the next start bit
        if (w_baud_zero) begin
          if (r_idx == STOP_LAST) begin
            w_done = 1'b1;
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_shift_nxt = w_head;
              w_baud_nxt  = BAUD_LAST;
              w_state_nxt = S_START;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_idx_nxt  = r_idx + 3'd1;
            w_baud_nxt = BAUD_LAST;
          end
        end else begin
          w_baud_nxt = r_baud - BW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_idx    <= 3'd0;
      r_shift  <= 8'd0;
      r_tx     <= 1'b1;
      r_frames <= 16'd0;
      r_live   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_live  <= 1'b1;
      if (w_done) r_frames <= r_frames + 16'd1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

endmodule

// File: tb/tb_exploit_uart_tx.sv
// Scoreboard bench: drivers queue accepted bytes, per-DUT monitors check each frame bit-by-bit.
module tb_exploit_uart_tx;
  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data  [2];
  logic        s_valid [2];
  logic        s_ready [2];
  logic        tx      [2];
  logic        busy    [2];
  logic [15:0] tx_count[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done [2];
  int fr_start [2][64];
  int fr_end   [2][64];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exploit_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4), .STOP_BITS(1)) u_dut0 (
    .clk_in(clk), .rst_n(rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .tx(tx[0]), .busy(busy[0]), .tx_count(tx_count[0]));

  exploit_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4), .STOP_BITS(2)) u_dut1 (
    .clk_in(clk), .rst_n(rst_n), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .tx(tx[1]), .busy(busy[1]), .tx_count(tx_count[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference line level: slot 0 start, slots 1..8 data LSB first, then stop high.
  function automatic logic exp_bit(input logic [7:0] b, input int p);
    int slot;
    slot = p / C;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push_exp(input int d, input logic [7:0] b);
    if (d == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic pop_exp(input int d, output logic [7:0] b);
    if (d == 0) b = q0.pop_front(); else b = q1.pop_front();
  endtask

  task automatic mon(input int d);
    int L;
    int pos;
    int errs;
    bit act;
    bit pend;
    logic [7:0] b;
    logic [15:0] exp_cnt;
    L = (9 + ((d == 0) ? 1 : 2)) * C;
    pos = 0; errs = 0; act = 0; pend = 0; b = 8'h00; exp_cnt = 16'd0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        act = 0; pend = 0; exp_cnt = 16'd0;
        if (d == 0) q0.delete(); else q1.delete();
      end else begin
        if (pend) begin
          chk($sformatf("tx_count dut%0d", d), 32'(tx_count[d]), 32'(exp_cnt));
          chk($sformatf("busy after frame dut%0d", d), 32'(busy[d]), 32'(qsize(d) != 0));
          fr_end[d][n_done[d] % 64] = cyc;
          n_done[d]++;
          pend = 0;
        end
        if (act) begin
          if (tx[d] !== exp_bit(b, pos)) errs++;
          pos++;
          if (pos == L) begin
            chk($sformatf("frame bits dut%0d byte %0h", d, b), 32'(errs), 0);
            act = 0; pend = 1; exp_cnt = exp_cnt + 16'd1;
          end
        end else if (tx[d] === 1'b0) begin
          if (qsize(d) == 0) begin
            chk($sformatf("unexpected frame dut%0d", d), 1, 0);
            b = 8'h00;
          end else begin
            pop_exp(d, b);
          end
          fr_start[d][n_done[d] % 64] = cyc;
          act = 1; pos = 1; errs = 0;
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int d, input logic [7:0] b, output int acc);
    int n;
    n = 0;
    s_data[d]  = b;
    s_valid[d] = 1'b1;
    while (s_ready[d] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (s_ready[d] !== 1'b1) begin
      chk("accept timeout", 0, 1);
      acc = -1;
    end else begin
      @(posedge clk);
      push_exp(d, b);
      @(negedge clk);
      acc = cyc;
    end
  endtask

  task automatic wait_done(input int d, input int target);
    int n;
    n = 0;
    while (n_done[d] < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n_done[d] < target) chk("frame wait timeout", 32'(n_done[d]), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int acc[6];
    int base;
    int tgt;
    int n;
    int d;
    int gap;
    rst_n = 1'b0;
    n_done[0] = 0; n_done[1] = 0;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = 8'h00;
    end

    // reset state
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx[0]), 1);
    chk("reset busy", 32'(busy[0]), 0);
    chk("reset tx_count", 32'(tx_count[0]), 0);
    chk("reset s_ready", 32'(s_ready[0]), 0);
    chk("reset tx dut1", 32'(tx[1]), 1);
    rst_n = 1'b1;
    chk("s_ready before first edge", 32'(s_ready[0]), 0);
    @(negedge clk);
    chk("s_ready after release", 32'(s_ready[0]), 1);
    chk("s_ready after release dut1", 32'(s_ready[1]), 1);

    // single byte
    base = n_done[0];
    send(0, 8'hFA, acc[0]);
    s_valid[0] = 1'b0;
    wait_done(0, base + 1);
    chk("single latency", 32'(fr_start[0][base]), 32'(acc[0] + 1));
    chk("single length", 32'(fr_end[0][base]), 32'(acc[0] + 1 + 40));

    // burst
    base = n_done[0];
    send(0, 8'hFA, acc[0]);
    send(0, 8'hEB, acc[1]);
    send(0, 8'h11, acc[2]);
    send(0, 8'hDD, acc[3]);
    s_valid[0] = 1'b0;
    chk("burst consecutive accept", 32'(acc[3] - acc[0]), 3);
    wait_done(0, base + 4);
    for (int k = 1; k < 4; k++)
      chk($sformatf("burst gap %0d", k), 32'(fr_start[0][base+k] - fr_start[0][base+k-1]), 40);
    chk("burst end", 32'(fr_end[0][base+3]), 32'(acc[0] + 1 + 160));

    // backpressure
    base = n_done[0];
    for (int i = 0; i < 5; i++) send(0, 8'hA0 + 8'(i * 7), acc[i]);
    chk("full s_ready", 32'(s_ready[0]), 0);
    send(0, 8'h3C, acc[5]);
    s_valid[0] = 1'b0;
    chk("bp consecutive accept", 32'(acc[4] - acc[0]), 4);
    chk("bp sixth accept", 32'(acc[5]), 32'(acc[0] + 1 + 41));
    wait_done(0, base + 6);

    // two stop bits
    base = n_done[1];
    send(1, 8'h55, acc[0]);
    send(1, 8'h55, acc[1]);
    s_valid[1] = 1'b0;
    wait_done(1, base + 2);
    chk("2stop frame len", 32'(fr_start[1][base+1] - fr_start[1][base]), 44);
    chk("2stop end", 32'(fr_end[1][base+1]), 32'(acc[0] + 1 + 88));

    // reset mid-frame: during data bit 3 of the second queued byte
    base = n_done[0];
    send(0, 8'($urandom), acc[0]);
    send(0, 8'($urandom), acc[1]);
    send(0, 8'($urandom), acc[2]);
    s_valid[0] = 1'b0;
    tgt = acc[0] + 1 + 40 + 4 * C + 1;
    n = 0;
    while (cyc < tgt && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached bit 3", 32'(cyc >= tgt), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset tx", 32'(tx[0]), 1);
    chk("midreset busy", 32'(busy[0]), 0);
    chk("midreset tx_count", 32'(tx_count[0]), 0);
    chk("midreset s_ready", 32'(s_ready[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (50) @(negedge clk);
    chk("no resumed frame", 32'(tx[0]), 1);
    base = n_done[0];
    send(0, 8'h11, acc[0]);
    s_valid[0] = 1'b0;
    wait_done(0, base + 1);
    chk("post-reset tx_count", 32'(tx_count[0]), 1);

    // randomized traffic on both transmitters
    for (int i = 0; i < 14; i++) begin
      d   = int'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 60));
      send(d, 8'($urandom), acc[0]);
      s_valid[d] = 1'b0;
      repeat (gap) @(negedge clk);
    end
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy[0] || busy[1]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("random drained", 32'(q0.size() + q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
